int2flt_seq: RTL

- Multicycle controller that sequences the 16-bit integer-to-float conversion datapath over the shared byte-wide data memory.
- Reads a two's-complement operand from dm[SRC_ADDR..SRC_ADDR+1], little-endian.
- Normalizes it with an iterative one-bit-per-cycle shifter, packs {sign, exp[4:0], mant[9:0]}, and writes the result to dm[DST_ADDR..DST_ADDR+1].
- Uses the same start/done job handshake as the program top level.

---
 rtl/int2flt_pkg.sv | 43 ++++
 rtl/int2flt_pack.sv | 34 +++
 rtl/int2flt_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/int2flt_pkg.sv
// int2flt_pkg
//   Shared types and constants for the 16-bit integer-to-float sequencer.
//   Holds the controller state enum, the float field widths, the exponent
//   constants used by normalization and packing, and a priority-encoder
//   helper used by the single-cycle normalizer build (INT2FLT_FAST_NORM_EN).
package int2flt_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAPTURE,
    ST_NORM,
    ST_PACK,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_t;

  localparam int FLT_W  = 16;
  localparam int MANT_W = 10;
  localparam int EXP_W  = 5;

  // Exponent of an operand whose MSB already sits at bit 14.
  localparam logic [EXP_W-1:0] EXP_INIT       = 5'd21;
  // Exponent reached when the MSB was bit 0 (14 shifts).
  localparam logic [EXP_W-1:0] EXP_MIN        = 5'd7;
  // Exponent used for the -32768 special case.
  localparam logic [EXP_W-1:0] EXP_NEG_FULL   = 5'd22;
  // At or above this exponent the hidden bit is dropped from the field.
  localparam logic [EXP_W-1:0] EXP_HIDDEN_MIN = 5'd16;

  // Index of the most significant set bit; 0 when the value is zero.
  function automatic logic [3:0] msb_index(input logic [14:0] v);
    logic [3:0] p;
    p = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (v[i]) p = 4'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/int2flt_pack.sv
// int2flt_pack
//   Combinational packer that turns the normalized magnitude, exponent and
//   sign into the 16-bit {sign, exp[4:0], mant[9:0]} word.
//   Ports:
//     sign     - operand sign
//     exponent - exponent after normalization
//     mag      - normalized magnitude (bits 14:0)
//     orig     - magnitude before normalization (bits 14:0)
//     result   - packed float
module int2flt_pack
  import int2flt_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exponent,
  input  logic [14:0]       mag,
  input  logic [14:0]       orig,
  output logic [FLT_W-1:0]  result
);

  // A zero low field means either 0 or -32768. Small exponents keep the
  // un-normalized original magnitude, MSB included; orig is below 512 there,
  // so the field cannot overflow into the exponent.
  always_comb begin
    result = '0;
    if (mag == '0) begin
      result = sign ? {1'b1, EXP_NEG_FULL, {MANT_W{1'b0}}} : '0;
    end else if (exponent >= EXP_HIDDEN_MIN) begin
      result = {sign, exponent, mag[13:4]};
    end else begin
      result = {sign, exponent, orig[MANT_W-1:0]};
    end
  end

endmodule

// File: rtl/int2flt_seq.sv
// int2flt_seq
//   Multicycle controller: reads a little-endian 16-bit two's-complement
//   operand from dm[SRC_ADDR..SRC_ADDR+1], normalizes it, packs it as
//   {sign, exp[4:0], mant[9:0]} and writes it to dm[DST_ADDR..DST_ADDR+1].
//   Optional macro INT2FLT_FAST_NORM_EN: normalize in one cycle with a
//   priority encoder instead of one bit per cycle.
//   Ports:
//     clk       - clock, rising edge
//     rst       - asynchronous active-low reset
//     start     - job request, level-sampled in IDLE
//     done      - job complete, held in DONE
//     busy      - high outside IDLE and DONE
//     mem_addr  - memory address
//     mem_wen   - memory write enable
//     mem_wdata - memory write data
//     mem_rdata - memory read data, one cycle after the address
//     result    - last packed float
module int2flt_seq
  import int2flt_pkg::*;
#(
  parameter int AW       = 8,
  parameter int SRC_ADDR = 0,
  parameter int DST_ADDR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_wen,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic [FLT_W-1:0] result
);

  // Addresses are truncated to AW bits so +1 wraps around the memory.
  localparam logic [AW-1:0] SRC_LO = AW'(SRC_ADDR);
  localparam logic [AW-1:0] SRC_HI = AW'(SRC_ADDR + 1);
  localparam logic [AW-1:0] DST_LO = AW'(DST_ADDR);
  localparam logic [AW-1:0] DST_HI = AW'(DST_ADDR + 1);

  state_t           state;
  logic [7:0]       lo_byte;
  logic             sign_r;
  logic [EXP_W-1:0] exp_r;
  logic [14:0]      mag_r;
  logic [14:0]      orig_r;
  logic [FLT_W-1:0] pack_out;

  logic [15:0]      x_word;
  logic [15:0]      x_neg;
  logic [14:0]      x_mag;

  // The high byte arrives in CAPTURE; bit 15 of the magnitude only matters
  // for -32768, which is recognised by a zero low field.
  always_comb begin
    x_word = {mem_rdata, lo_byte};
    x_neg  = ~x_word + 16'd1;
    x_mag  = x_word[15] ? x_neg[14:0] : x_word[14:0];
  end

`ifdef INT2FLT_FAST_NORM_EN
  logic [3:0]       shift_amt;
  logic [14:0]      norm_mag;
  logic [EXP_W-1:0] norm_exp;

  // The shift needed to bring the MSB to bit 14, applied in one step.
  always_comb begin
    shift_amt = (mag_r == '0) ? 4'd0 : (4'd14 - msb_index(mag_r));
    norm_mag  = mag_r << shift_amt;
    norm_exp  = EXP_INIT - {1'b0, shift_amt};
  end
`else
  logic norm_exit;

  always_comb begin
    norm_exit = (mag_r == '0) || mag_r[14] || (exp_r == EXP_MIN);
  end
`endif

  int2flt_pack u_pack (
    .sign     (sign_r),
    .exponent (exp_r),
    .mag      (mag_r),
    .orig     (orig_r),
    .result   (pack_out)
  );

  // Outputs are registered alongside the state so they always reflect the
  // state being entered. Memory strobes default low and only the two read
  // and two write states drive an address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      result    <= '0;
      lo_byte   <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      mag_r     <= '0;
      orig_r    <= '0;
    end else begin
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RD_LO;
            busy     <= 1'b1;
            mem_addr <= SRC_LO;
          end
        end
        ST_RD_LO: begin
          state    <= ST_RD_HI;
          mem_addr <= SRC_HI;
        end
        ST_RD_HI: begin
          lo_byte <= mem_rdata;
          state   <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          sign_r <= x_word[15];
          mag_r  <= x_mag;
          orig_r <= x_mag;
          exp_r  <= EXP_INIT;
          state  <= ST_NORM;
        end
        ST_NORM: begin
`ifdef INT2FLT_FAST_NORM_EN
          mag_r <= norm_mag;
          exp_r <= norm_exp;
          state <= ST_PACK;
`else
          if (norm_exit) begin
            state <= ST_PACK;
          end else begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - 1'b1;
          end
`endif
        end
        ST_PACK: begin
          result    <= pack_out;
          state     <= ST_WR_LO;
          mem_wen   <= 1'b1;
          mem_addr  <= DST_LO;
          mem_wdata <= pack_out[7:0];
        end
        ST_WR_LO: begin
          state     <= ST_WR_HI;
          mem_wen   <= 1'b1;
          mem_addr  <= DST_HI;
          mem_wdata <= result[15:8];
        end
        ST_WR_HI: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
